rect_motion_ctrl: RTL and testbench
===================================

Name: rect_motion_ctrl

Overview:
- Per-frame position scheduler for one textured-rectangle draw stage. Drives that stage's xpos/ypos inputs.
- Auto-moves (bounces) the rectangle inside the visible area at a fixed step per frame.
- Also accepts absolute position load commands over a valid/ready handshake.
- All position changes take effect only at the start of vertical blanking, so a rectangle never tears mid-frame. Sits beside the draw stage, fed by the VGA timing bus vblnk.

Parameters:
SCREEN_W, 800, visible width in pixels
SCREEN_H, 600, visible height in lines
RECT_WIDTH, 64, rectangle width (draw stage covers xpos..xpos+RECT_WIDTH inclusive)
RECT_HEIGHT, 64, rectangle height (inclusive, as above)
STEP_X, 2, horizontal pixels moved per frame
STEP_Y, 1, vertical lines moved per frame
X_INIT, 0, xpos after reset
Y_INIT, 0, ypos after reset

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
vblnk_in  in  1  vertical blank from timing bus
enable  in  1  1 = auto-motion on
cmd_valid  in  1  load command present
cmd_ready  out  1  controller can accept a command
cmd_x  in  12  requested xpos
cmd_y  in  12  requested ypos
xpos  out  12  rectangle x to draw stage (registered)
ypos  out  12  rectangle y to draw stage (registered)
dir_x  out  1  0 = moving right, 1 = left
dir_y  out  1  0 = moving down, 1 = up
frame_tick  out  1  one-cycle pulse per frame
bounce  out  1  one-cycle pulse when any edge is hit

Behaviour:
- Limits: XMAX = SCREEN_W-1-RECT_WIDTH, YMAX = SCREEN_H-1-RECT_HEIGHT. All arithmetic is 13-bit unsigned; no wrap-around is permitted.
- Reset (rst=0 at a pclk edge):
  - xpos=X_INIT, ypos=Y_INIT, dir_x=0, dir_y=0, frame_tick=0, bounce=0, cmd_ready=0, state=IDLE.
  - Internal vblnk_d=1, so a vblnk already high at reset release gives no tick.
  - Reset asserted mid-LOAD discards the pending command.
- Tick detect: tick = vblnk_in & ~vblnk_d, with vblnk_d registered every cycle. frame_tick is registered tick (1 cycle after the vblnk rising edge). Any position/dir update is applied on that same edge.
- cmd_ready = 1 in IDLE and RUN, 0 in LOAD and during reset. Accept = cmd_valid & cmd_ready.
- On accept, latch x_pend = min(cmd_x, XMAX) and y_pend = min(cmd_y, YMAX), then enter LOAD.
- States:
  - IDLE: positions hold. Accept -> LOAD; else enable=1 -> RUN.
  - RUN: on tick with enable=1, apply motion. Accept -> LOAD; else enable=0 -> IDLE (next cycle, no further motion).
  - LOAD: wait for tick. On tick: xpos=x_pend, ypos=y_pend, no motion, dirs unchanged. Then go to RUN if enable, else IDLE.
- Motion, X axis (Y is identical with STEP_Y/YMAX/dir_y):
  - dir_x=0: if xpos+STEP_X >= XMAX then xpos=XMAX, dir_x=1, bounce; else xpos += STEP_X.
  - dir_x=1: if xpos <= STEP_X then xpos=0, dir_x=0, bounce; else xpos -= STEP_X.
- Corner hit (both axes bounce on one tick) gives a single bounce pulse; both dirs flip.
- Accept and tick in the same RUN cycle: that tick's motion is applied, the command is latched, and the new position lands on the following tick.
- A command that arrives while in LOAD waits (cmd_ready=0); cmd_valid must be held by the source.
- bounce and frame_tick are 1-cycle pulses and are 0 at all other times.
- Latency from vblnk rising edge to new xpos/ypos: 1 pclk.

Test Plan:
- Reset with vblnk_in=1, release rst, vblnk stays high 10 cycles -> no frame_tick; xpos=0, ypos=0, cmd_ready=1 one cycle after release.
- enable=1, defaults, 3 vblnk rising edges -> xpos 2,4,6; ypos 1,2,3; frame_tick pulses 1 cycle after each edge.
- Force xpos=734 via command, enable=1, next tick -> xpos=735 (XMAX), dir_x=1, bounce=1; following tick -> xpos=733.
- Command cmd_x=4000, cmd_y=100, enable=0 -> cmd_ready drops; xpos unchanged until the next vblnk edge, then xpos=735, ypos=100, state IDLE, cmd_ready=1.
- Command accepted on the same cycle as a tick in RUN at xpos=10 -> xpos=12 now, then cmd_x on the next tick.
- Drop enable mid-RUN, apply 2 ticks -> xpos/ypos frozen, frame_tick still pulses, bounce=0.

Source files
------------

// File: rtl/rect_motion_ctrl_if.sv
// Command channel of the rectangle position scheduler.
// A source places an absolute position on cmd_x/cmd_y and holds cmd_valid
// until the controller answers with cmd_ready in the same cycle.
interface rect_motion_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_x;
    logic [11:0] cmd_y;

    modport master (
        output cmd_valid,
        output cmd_x,
        output cmd_y,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_x,
        input  cmd_y,
        output cmd_ready
    );
endinterface

// File: rtl/rect_motion_ctrl.sv
// Per-frame position scheduler for one textured-rectangle draw stage.
// The rectangle bounces inside the visible area at a fixed step per frame, or
// jumps to an absolute position loaded over the command channel. Every change
// lands on the cycle after the rising edge of vblnk, so the draw stage never
// sees a position change in the middle of a frame.
module rect_motion_ctrl #(
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int RECT_WIDTH  = 64,
    parameter int RECT_HEIGHT = 64,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 1,
    parameter int X_INIT      = 0,
    parameter int Y_INIT      = 0
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               vblnk_in,
    input  logic               enable,
    rect_motion_ctrl_if.slave  cmd,
    output logic [11:0]        xpos,
    output logic [11:0]        ypos,
    output logic               dir_x,
    output logic               dir_y,
    output logic               frame_tick,
    output logic               bounce
);

    // The draw stage covers xpos..xpos+RECT_WIDTH inclusive, hence the extra -1.
    // Comparisons are done one bit wider so that pos+step can never wrap.
    localparam logic [12:0] XMAX13  = 13'(SCREEN_W - 1 - RECT_WIDTH);
    localparam logic [12:0] YMAX13  = 13'(SCREEN_H - 1 - RECT_HEIGHT);
    localparam logic [11:0] XMAX12  = XMAX13[11:0];
    localparam logic [11:0] YMAX12  = YMAX13[11:0];
    localparam logic [12:0] STEPX13 = 13'(STEP_X);
    localparam logic [12:0] STEPY13 = 13'(STEP_Y);
    localparam logic [11:0] STEPX12 = STEPX13[11:0];
    localparam logic [11:0] STEPY12 = STEPY13[11:0];
    localparam logic [11:0] XINIT12 = 12'(X_INIT);
    localparam logic [11:0] YINIT12 = 12'(Y_INIT);

    typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

    state_t      state;
    state_t      next_state;
    logic        vblnk_d;
    logic        tick;
    logic        accept;
    logic        cmd_ready_q;
    logic        do_move;
    logic        do_load;
    logic [11:0] x_pend;
    logic [11:0] y_pend;
    logic [11:0] x_next;
    logic [11:0] y_next;
    logic        dir_x_next;
    logic        dir_y_next;
    logic        bounce_x;
    logic        bounce_y;

    assign tick           = vblnk_in & ~vblnk_d;
    assign accept         = cmd.cmd_valid & cmd_ready_q;
    assign cmd.cmd_ready  = cmd_ready_q;

    // Next-state decode: a command always wins over enable, LOAD waits for the frame tick
    always_comb begin
        next_state = state;
        do_move    = 1'b0;
        do_load    = 1'b0;
        case (state)
            IDLE: begin
                if (accept)      next_state = LOAD;
                else if (enable) next_state = RUN;
            end
            RUN: begin
                do_move = tick & enable;
                if (accept)       next_state = LOAD;
                else if (!enable) next_state = IDLE;
            end
            LOAD: begin
                if (tick) begin
                    do_load    = 1'b1;
                    next_state = enable ? RUN : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One bounce step per axis: clamp onto the wall and reverse when the step would reach it
    always_comb begin
        x_next     = xpos + STEPX12;
        dir_x_next = dir_x;
        bounce_x   = 1'b0;
        if (!dir_x) begin
            if ({1'b0, xpos} + STEPX13 >= XMAX13) begin
                x_next     = XMAX12;
                dir_x_next = 1'b1;
                bounce_x   = 1'b1;
            end
        end else if ({1'b0, xpos} <= STEPX13) begin
            x_next     = 12'd0;
            dir_x_next = 1'b0;
            bounce_x   = 1'b1;
        end else begin
            x_next = xpos - STEPX12;
        end

        y_next     = ypos + STEPY12;
        dir_y_next = dir_y;
        bounce_y   = 1'b0;
        if (!dir_y) begin
            if ({1'b0, ypos} + STEPY13 >= YMAX13) begin
                y_next     = YMAX12;
                dir_y_next = 1'b1;
                bounce_y   = 1'b1;
            end
        end else if ({1'b0, ypos} <= STEPY13) begin
            y_next     = 12'd0;
            dir_y_next = 1'b0;
            bounce_y   = 1'b1;
        end else begin
            y_next = ypos - STEPY12;
        end
    end

    // FSM state register
    always_ff @(posedge pclk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // vblank edge detector, frame pulse and ready flag; vblnk_d starts high so a blank held through reset gives no tick
    always_ff @(posedge pclk) begin
        if (!rst) begin
            vblnk_d     <= 1'b1;
            frame_tick  <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            vblnk_d     <= vblnk_in;
            frame_tick  <= tick;
            cmd_ready_q <= (next_state != LOAD);
        end
    end

    // Latch the accepted command already clamped to the visible area
    always_ff @(posedge pclk) begin
        if (!rst) begin
            x_pend <= XINIT12;
            y_pend <= YINIT12;
        end else if (accept) begin
            x_pend <= ({1'b0, cmd.cmd_x} > XMAX13) ? XMAX12 : cmd.cmd_x;
            y_pend <= ({1'b0, cmd.cmd_y} > YMAX13) ? YMAX12 : cmd.cmd_y;
        end
    end

    // Position and direction registers; a corner hit yields one bounce pulse
    always_ff @(posedge pclk) begin
        if (!rst) begin
            xpos   <= XINIT12;
            ypos   <= YINIT12;
            dir_x  <= 1'b0;
            dir_y  <= 1'b0;
            bounce <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (do_move) begin
                xpos   <= x_next;
                ypos   <= y_next;
                dir_x  <= dir_x_next;
                dir_y  <= dir_y_next;
                bounce <= bounce_x | bounce_y;
            end else if (do_load) begin
                xpos <= x_pend;
                ypos <= y_pend;
            end
        end
    end

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Self-checking bench for rect_motion_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a frame-level reference model.
module tb_rect_motion_ctrl;

    localparam int XMAX   = 800 - 1 - 64;
    localparam int YMAX   = 600 - 1 - 64;
    localparam int STEP_X = 2;
    localparam int STEP_Y = 1;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vblnk_in;
    logic        enable;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        dir_x;
    logic        dir_y;
    logic        frame_tick;
    logic        bounce;

    rect_motion_ctrl_if cmd_bus ();

    rect_motion_ctrl dut (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .enable     (enable),
        .cmd        (cmd_bus),
        .xpos       (xpos),
        .ypos       (ypos),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .frame_tick (frame_tick),
        .bounce     (bounce)
    );

    // Free-running pixel clock
    always #5 pclk = ~pclk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: rectangle position, headings, pending command and whether one is waiting
    int m_x, m_y, m_px, m_py;
    bit m_dx, m_dy, m_ft, m_b, m_rdy, m_vd, m_acc;
    bit m_running;
    bit m_pending;

    function automatic void stepAxis(input int pos, input bit dir, input int step, input int lim,
                                     output int npos, output bit ndir, output bit hit);
        npos = pos; ndir = dir; hit = 1'b0;
        if (!dir) begin
            if (pos + step >= lim) begin npos = lim; ndir = 1'b1; hit = 1'b1; end
            else npos = pos + step;
        end else begin
            if (pos <= step) begin npos = 0; ndir = 1'b0; hit = 1'b1; end
            else npos = pos - step;
        end
    endfunction

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Advance the model by one pclk edge using the inputs the DUT sampled on it
    function automatic void modelEdge();
        bit tick, hx, hy;
        int nx, ny;
        bit ndx, ndy;
        if (!rst) begin
            m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_ft = 0; m_b = 0;
            m_rdy = 0; m_vd = 1; m_acc = 0; m_running = 0; m_pending = 0;
        end else begin
            tick  = vblnk_in && !m_vd;
            m_vd  = vblnk_in;
            m_ft  = tick;
            m_b   = 1'b0;
            m_acc = cmd_bus.cmd_valid && m_rdy;
            if (m_pending) begin
                if (tick) begin
                    m_x = m_px; m_y = m_py;
                    m_pending = 1'b0;
                    m_running = enable;
                end
            end else begin
                if (m_running && tick && enable) begin
                    stepAxis(m_x, m_dx, STEP_X, XMAX, nx, ndx, hx);
                    stepAxis(m_y, m_dy, STEP_Y, YMAX, ny, ndy, hy);
                    m_x = nx; m_dx = ndx; m_y = ny; m_dy = ndy;
                    m_b = hx | hy;
                end
                if (m_acc) begin
                    m_px = minInt(int'(cmd_bus.cmd_x), XMAX);
                    m_py = minInt(int'(cmd_bus.cmd_y), YMAX);
                    m_pending = 1'b1;
                end else begin
                    m_running = enable;
                end
            end
            m_rdy = !m_pending;
        end
    endfunction

    task automatic checkOne(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("xpos",       {1'b0, xpos},        13'(m_x));
        checkOne("ypos",       {1'b0, ypos},        13'(m_y));
        checkOne("dir_x",      {12'd0, dir_x},      {12'd0, m_dx});
        checkOne("dir_y",      {12'd0, dir_y},      {12'd0, m_dy});
        checkOne("frame_tick", {12'd0, frame_tick}, {12'd0, m_ft});
        checkOne("bounce",     {12'd0, bounce},     {12'd0, m_b});
        checkOne("cmd_ready",  {12'd0, cmd_bus.cmd_ready}, {12'd0, m_rdy});
    endtask

    task automatic applyStimulus(input bit r, input bit vb, input bit en, input bit cv,
                                 input logic [11:0] cx, input logic [11:0] cy);
        rst               = r;
        vblnk_in          = vb;
        enable            = en;
        cmd_bus.cmd_valid = cv;
        cmd_bus.cmd_x     = cx;
        cmd_bus.cmd_y     = cy;
        @(posedge pclk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    // Three blanking-low cycles, then the vblnk rising edge; outputs afterwards show that tick
    task automatic tickFrame(input bit en);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, en, 1'b0, 12'd0, 12'd0);
        applyStimulus(1'b1, 1'b1, en, 1'b0, 12'd0, 12'd0);
    endtask

    // Hold a command until the controller takes it, with a bounded wait
    task automatic sendCmd(input bit en, input logic [11:0] cx, input logic [11:0] cy);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            applyStimulus(1'b1, 1'b0, en, 1'b1, cx, cy);
            got = m_acc;
        end
        checkOne("cmd_accepted", {12'd0, got}, 13'd1);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    bit          r_vb, r_en, r_cv, r_rst;
    logic [11:0] r_cx, r_cy;

    initial begin
        $display("[TB] reset with vblank high");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
        checkOne("ready_after_release", {12'd0, cmd_bus.cmd_ready}, 13'd1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
        checkOne("no_tick_while_high", {12'd0, frame_tick}, 13'd0);
        checkOne("x_after_reset", {1'b0, xpos}, 13'd0);

        $display("[TB] auto motion over three frames");
        for (int k = 1; k <= 3; k++) begin
            tickFrame(1'b1);
            checkOne("run_x", {1'b0, xpos}, 13'(2 * k));
            checkOne("run_y", {1'b0, ypos}, 13'(k));
            checkOne("run_tick", {12'd0, frame_tick}, 13'd1);
        end

        $display("[TB] right wall bounce");
        sendCmd(1'b1, 12'd734, 12'd0);
        tickFrame(1'b1);
        checkOne("load_734", {1'b0, xpos}, 13'd734);
        tickFrame(1'b1);
        checkOne("wall_x", {1'b0, xpos}, 13'd735);
        checkOne("wall_dir", {12'd0, dir_x}, 13'd1);
        checkOne("wall_bounce", {12'd0, bounce}, 13'd1);
        tickFrame(1'b1);
        checkOne("after_wall_x", {1'b0, xpos}, 13'd733);

        $display("[TB] clamped load while disabled");
        sendCmd(1'b0, 12'd4000, 12'd100);
        checkOne("ready_low_in_load", {12'd0, cmd_bus.cmd_ready}, 13'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
        checkOne("hold_before_tick", {1'b0, xpos}, 13'd733);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
        checkOne("clamp_x", {1'b0, xpos}, 13'd735);
        checkOne("load_y", {1'b0, ypos}, 13'd100);
        checkOne("ready_after_load", {12'd0, cmd_bus.cmd_ready}, 13'd1);
        tickFrame(1'b0);
        checkOne("idle_hold_x", {1'b0, xpos}, 13'd735);

        $display("[TB] command on the same cycle as a tick");
        sendCmd(1'b1, 12'd1, 12'd50);
        tickFrame(1'b1);
        tickFrame(1'b1);
        checkOne("left_wall_x", {1'b0, xpos}, 13'd0);
        checkOne("left_wall_bounce", {12'd0, bounce}, 13'd1);
        sendCmd(1'b1, 12'd10, 12'd50);
        tickFrame(1'b1);
        checkOne("load_10", {1'b0, xpos}, 13'd10);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'd300, 12'd200);
        cmd_bus.cmd_valid = 1'b0;
        checkOne("same_cycle_move", {1'b0, xpos}, 13'd12);
        checkOne("same_cycle_ready", {12'd0, cmd_bus.cmd_ready}, 13'd0);
        tickFrame(1'b1);
        checkOne("same_cycle_land_x", {1'b0, xpos}, 13'd300);
        checkOne("same_cycle_land_y", {1'b0, ypos}, 13'd200);

        $display("[TB] freeze when disabled");
        tickFrame(1'b1);
        for (int k = 0; k < 2; k++) begin
            tickFrame(1'b0);
            checkOne("frozen_x", {1'b0, xpos}, 13'd302);
            checkOne("frozen_y", {1'b0, ypos}, 13'd201);
            checkOne("frozen_tick", {12'd0, frame_tick}, 13'd1);
            checkOne("frozen_bounce", {12'd0, bounce}, 13'd0);
        end

        $display("[TB] randomized traffic");
        r_vb = 1'b0; r_en = 1'b1; r_cv = 1'b0; r_cx = 12'd0; r_cy = 12'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) r_vb = ~r_vb;
            if ($urandom_range(0, 59) == 0) r_en = ~r_en;
            r_rst = ($urandom_range(0, 299) != 0);
            if (!r_cv && $urandom_range(0, 39) == 0) begin
                r_cv = 1'b1;
                r_cx = 12'($urandom_range(0, 4095));
                r_cy = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 4095))
                                                   : 12'($urandom_range(520, 540));
            end
            applyStimulus(r_rst, r_vb, r_en, r_cv, r_cx, r_cy);
            if (m_acc || !r_rst) r_cv = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
